fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer.sv | 116 +++++++++++
 tb/tb_fetch_buffer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Instruction fetch front end: issues one fetch at a time and queues returned
// words with their addresses in a small FIFO for decode.
module fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       tag_q, tag_d;
  logic [PW:0]       count_q, count_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [31:0]       instr_mem_q [DEPTH];
  logic [31:0]       instr_mem_d [DEPTH];
  logic [31:0]       pc_mem_q    [DEPTH];
  logic [31:0]       pc_mem_d    [DEPTH];

  logic issue, push, pop;
  logic unused_rpc_lsb;

  assign unused_rpc_lsb = ^redirect_pc[1:0];

  assign issue = (state_q == IDLE) && !redirect && (count_q != FULL);
  assign push  = (state_q == WAIT) && imem_ack && !redirect;
  assign pop   = (count_q != '0) && out_ready && !redirect;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    tag_d       = tag_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;

    case (state_q)
      IDLE: if (issue) begin
        tag_d      = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
        state_d    = WAIT;
      end
      WAIT: begin
        if (redirect) state_d = imem_ack ? IDLE : DROP;
        else if (imem_ack) state_d = IDLE;
      end
      DROP: if (imem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (push) begin
      instr_mem_d[wr_ptr_q] = imem_rdata;
      pc_mem_d[wr_ptr_q]    = tag_q;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    // Redirect overrides both queue updates and the PC advance above.
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      tag_q       <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      instr_mem_q <= '{default: '0};
      pc_mem_q    <= '{default: '0};
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      tag_q       <= tag_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      instr_mem_q <= instr_mem_d;
      pc_mem_q    <= pc_mem_d;
    end
  end

  assign imem_req  = rst && issue;
  assign imem_addr = rst ? fetch_pc_q : '0;
  assign out_valid = rst && (count_q != '0);
  assign out_instr = rst ? instr_mem_q[rd_ptr_q] : '0;
  assign out_pc    = rst ? pc_mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: streaming, backpressure, redirects, PC wrap
// and reset abandoning an outstanding fetch.
module tb_fetch_buffer;

  logic        clk;
  logic        rst;
  logic        imem_req, imem_ack, redirect, out_valid, out_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, out_instr, out_pc;

  logic        req2, ack2, valid2;
  logic [31:0] addr2, instr2, pc2;

  int unsigned checks = 0;
  int unsigned errors = 0;

  fetch_buffer #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  fetch_buffer #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(32'h0),
    .redirect(1'b0), .redirect_pc(32'h0),
    .out_valid(valid2), .out_ready(1'b1),
    .out_instr(instr2), .out_pc(pc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0;
    redirect_pc = '0; out_ready = 1'b0; ack2 = 1'b0;
    #1 rst = 1'b0;

    // In reset
    @(negedge clk); #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_req2", {31'b0, req2}, 32'd0);

    // Streaming with ack one cycle after each request
    @(negedge clk); rst = 1'b1; out_ready = 1'b1; #1;
    chk("s0_req", {31'b0, imem_req}, 32'd1);
    chk("s0_addr", imem_addr, 32'h0);
    chk("w0_addr", addr2, 32'hFFFF_FFFC);
    chk("w0_req", {31'b0, req2}, 32'd1);
    @(negedge clk); imem_ack = 1'b1; imem_rdata = 32'hA000_0000; ack2 = 1'b1; #1;
    chk("s0_wait_req", {31'b0, imem_req}, 32'd0);
    chk("s0_wait_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk); imem_ack = 1'b0; ack2 = 1'b0; #1;
    chk("s0_valid", {31'b0, out_valid}, 32'd1);
    chk("s0_pc", out_pc, 32'h0);
    chk("s0_instr", out_instr, 32'hA000_0000);
    chk("s1_addr", imem_addr, 32'h4);
    chk("s1_req", {31'b0, imem_req}, 32'd1);
    chk("w1_addr", addr2, 32'h0000_0000);
    chk("w1_req", {31'b0, req2}, 32'd1);
    @(negedge clk); imem_ack = 1'b1; imem_rdata = 32'hA000_0004; #1;
    chk("s1_wait_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk); imem_ack = 1'b0; #1;
    chk("s1_pc", out_pc, 32'h4);
    chk("s1_instr", out_instr, 32'hA000_0004);
    chk("s2_addr", imem_addr, 32'h8);
    @(negedge clk); imem_ack = 1'b1; imem_rdata = 32'hA000_0008; #1;

    // Backpressure: head at pc 8 held, one more fetch fills DEPTH=2
    @(negedge clk); imem_ack = 1'b0; out_ready = 1'b0; #1;
    chk("s2_pc", out_pc, 32'h8);
    chk("s2_instr", out_instr, 32'hA000_0008);
    chk("bp_req", {31'b0, imem_req}, 32'd1);
    chk("bp_addr", imem_addr, 32'hC);
    @(negedge clk); imem_ack = 1'b1; imem_rdata = 32'hA000_000C; #1;
    chk("bp_wait_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk); imem_ack = 1'b0; #1;
    chk("full_req", {31'b0, imem_req}, 32'd0);
    chk("full_pc", out_pc, 32'h8);
    @(negedge clk); #1;
    chk("full_req_hold", {31'b0, imem_req}, 32'd0);
    chk("full_valid", {31'b0, out_valid}, 32'd1);
    chk("full_instr_hold", out_instr, 32'hA000_0008);
    chk("full_pc_hold", out_pc, 32'h8);
    @(negedge clk); out_ready = 1'b1; #1;
    chk("full_pop_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk); #1;
    chk("resume_req", {31'b0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, 32'h10);
    chk("head3_pc", out_pc, 32'hC);
    chk("head3_instr", out_instr, 32'hA000_000C);

    // Redirect while waiting; late ack must be dropped
    @(negedge clk); redirect = 1'b1; redirect_pc = 32'h0000_0103; #1;
    chk("rd_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk); redirect = 1'b0; #1;
    chk("drop_valid", {31'b0, out_valid}, 32'd0);
    chk("drop_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk); #1;
    @(negedge clk); imem_ack = 1'b1; imem_rdata = 32'hDEAD_0010; #1;
    chk("drop_ack_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk); imem_ack = 1'b0; #1;
    chk("after_drop_valid", {31'b0, out_valid}, 32'd0);
    chk("redir_req", {31'b0, imem_req}, 32'd1);
    chk("redir_addr", imem_addr, 32'h0000_0100);
    @(negedge clk); imem_ack = 1'b1; imem_rdata = 32'hB000_0100; #1;
    chk("redir_wait_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk); imem_ack = 1'b0; #1;
    chk("redir_pc", out_pc, 32'h0000_0100);
    chk("redir_instr", out_instr, 32'hB000_0100);
    chk("redir_next_addr", imem_addr, 32'h0000_0104);

    // Redirect coinciding with ack
    @(negedge clk); imem_ack = 1'b1; imem_rdata = 32'hDEAD_0104;
    redirect = 1'b1; redirect_pc = 32'h0000_0200; #1;
    chk("rdack_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk); imem_ack = 1'b0; redirect = 1'b0; #1;
    chk("rdack_valid", {31'b0, out_valid}, 32'd0);
    chk("rdack_req_next", {31'b0, imem_req}, 32'd1);
    chk("rdack_addr", imem_addr, 32'h0000_0200);

    // Reset while waiting, then a stray ack after release
    @(negedge clk); rst = 1'b0; #1;
    chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk); rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_0200; #1;
    chk("post_rst_req", {31'b0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);
    @(negedge clk); imem_ack = 1'b0; #1;
    chk("stray_valid", {31'b0, out_valid}, 32'd0);
    chk("stray_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk); imem_ack = 1'b1; imem_rdata = 32'hC000_0000; #1;
    chk("stray_wait_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk); imem_ack = 1'b0; #1;
    chk("post_rst_valid", {31'b0, out_valid}, 32'd1);
    chk("post_rst_pc", out_pc, 32'h0);
    chk("post_rst_instr", out_instr, 32'hC000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
